// File: rtl/fp_mul_norm_round.sv
// Post-multiply stage of the FP multiplier: normalise the raw mantissa product,
// round to nearest-even, saturate/flush and pack, over a 2-stage valid/ready pipeline.
module fp_mul_norm_round #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_sign,
    input  logic [EXP_W+1:0]          in_exp,
    input  logic [2*MANT_W-1:0]       in_prod,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [EXP_W+MANT_W-1:0]   out_result,
    output logic                      out_overflow,
    output logic                      out_underflow
);

    localparam int PW = 2 * MANT_W;
    localparam int FW = MANT_W - 1;
    // One extra bit of headroom so the normalise and rounding increments can never wrap.
    localparam int XW = EXP_W + 3;
    localparam logic signed [XW-1:0] EXP_ZERO = '0;
    localparam logic signed [XW-1:0] EXP_ONE  = XW'(1);
    localparam logic signed [XW-1:0] EXP_MAX  = XW'((1 << EXP_W) - 1);

    logic s2_en, s1_en;

    logic                 s1_valid_q, s1_valid_d;
    logic                 s1_sign_q,  s1_sign_d;
    logic                 s1_zero_q,  s1_zero_d;
    logic signed [XW-1:0] s1_exp_q,   s1_exp_d;
    logic [FW-1:0]        s1_frac_q,  s1_frac_d;
    logic                 s1_g_q,     s1_g_d;
    logic                 s1_s_q,     s1_s_d;

    logic                       out_valid_q,  out_valid_d;
    logic [EXP_W+MANT_W-1:0]    out_result_q, out_result_d;
    logic                       out_ovf_q,    out_ovf_d;
    logic                       out_unf_q,    out_unf_d;

    logic signed [XW-1:0] exp_ext;
    logic                 rnd_up;
    logic                 rnd_c;
    logic [FW-1:0]        rnd_f;
    logic signed [XW-1:0] rnd_exp;

    assign s2_en    = !out_valid_q || out_ready;
    assign s1_en    = !s1_valid_q || s2_en;
    assign in_ready = s1_en && !rst;

    assign exp_ext = XW'($signed(in_exp));

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_zero_d  = s1_zero_q;
        s1_exp_d   = s1_exp_q;
        s1_frac_d  = s1_frac_q;
        s1_g_d     = s1_g_q;
        s1_s_d     = s1_s_q;
        if (s1_en) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_sign_d = in_sign;
                s1_zero_d = (in_prod == '0);
                if (in_prod[PW-1]) begin
                    s1_frac_d = in_prod[PW-2:MANT_W];
                    s1_g_d    = in_prod[MANT_W-1];
                    s1_s_d    = |in_prod[MANT_W-2:0];
                    s1_exp_d  = exp_ext + EXP_ONE;
                end else begin
                    s1_frac_d = in_prod[PW-3:MANT_W-1];
                    s1_g_d    = in_prod[MANT_W-2];
                    s1_s_d    = |in_prod[MANT_W-3:0];
                    s1_exp_d  = exp_ext;
                end
            end
        end
    end

    // A rounding carry leaves the fraction at zero and bumps the exponent before range checks.
    always_comb begin
        rnd_up         = s1_g_q && (s1_s_q || s1_frac_q[0]);
        {rnd_c, rnd_f} = {1'b0, s1_frac_q} + {{FW{1'b0}}, rnd_up};
        rnd_exp        = s1_exp_q + (rnd_c ? EXP_ONE : EXP_ZERO);
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_ovf_d    = out_ovf_q;
        out_unf_d    = out_unf_q;
        if (s2_en) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_ovf_d = 1'b0;
                out_unf_d = 1'b0;
                if (s1_zero_q) begin
                    out_result_d = {s1_sign_q, {(EXP_WIDTH_ALL()){1'b0}}};
                end else if (rnd_exp >= EXP_MAX) begin
                    out_result_d = {s1_sign_q, {EXP_W{1'b1}}, {FW{1'b0}}};
                    out_ovf_d    = 1'b1;
                end else if (rnd_exp <= EXP_ZERO) begin
                    out_result_d = {s1_sign_q, {(EXP_WIDTH_ALL()){1'b0}}};
                    out_unf_d    = 1'b1;
                end else begin
                    out_result_d = {s1_sign_q, rnd_exp[EXP_W-1:0], rnd_f};
                end
            end
        end
    end

    function automatic int EXP_WIDTH_ALL();
        return EXP_W + FW;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_sign_q    <= 1'b0;
            s1_zero_q    <= 1'b0;
            s1_exp_q     <= '0;
            s1_frac_q    <= '0;
            s1_g_q       <= 1'b0;
            s1_s_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_ovf_q    <= 1'b0;
            out_unf_q    <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_sign_q    <= s1_sign_d;
            s1_zero_q    <= s1_zero_d;
            s1_exp_q     <= s1_exp_d;
            s1_frac_q    <= s1_frac_d;
            s1_g_q       <= s1_g_d;
            s1_s_q       <= s1_s_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_ovf_q    <= out_ovf_d;
            out_unf_q    <= out_unf_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_result    = out_result_q;
    assign out_overflow  = out_ovf_q;
    assign out_underflow = out_unf_q;

endmodule

// File: tb/tb_fp_mul_norm_round.sv
// Directed bench for fp_mul_norm_round: hand-computed vectors, backpressure and mid-stream reset.
module tb_fp_mul_norm_round;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [9:0]  in_exp;
    logic [47:0] in_prod;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_overflow;
    logic        out_underflow;

    int checkCount  = 0;
    int errorCount  = 0;
    int acceptCount = 0;
    int bpBase      = 0;
    logic [33:0] expQ[$];

    fp_mul_norm_round #(.MANT_W(24), .EXP_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_sign       (in_sign),
        .in_exp        (in_exp),
        .in_prod       (in_prod),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_overflow  (out_overflow),
        .out_underflow (out_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Holds the beat until it is accepted, then queues its hand-computed result.
    task automatic applyStimulus(input logic sg, input logic [9:0] ex, input logic [47:0] p,
                                 input logic [31:0] res, input logic ov, input logic un);
        int waitCycles = 0;
        in_valid = 1'b1;
        in_sign  = sg;
        in_exp   = ex;
        in_prod  = p;
        @(negedge clk);
        while (!in_ready && waitCycles < 50) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!in_ready) begin
            checkOutput("accept_timeout", {63'd0, in_ready}, 64'd1);
        end else begin
            @(posedge clk);
            expQ.push_back({res, ov, un});
            acceptCount++;
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((expQ.size() != 0 || out_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain", 64'(expQ.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_out", {63'd0, out_valid}, 64'd0);
            end else begin
                logic [33:0] e;
                e = expQ.pop_front();
                checkOutput("result",    {32'd0, out_result},    {32'd0, e[33:2]});
                checkOutput("overflow",  {63'd0, out_overflow},  {63'd0, e[1]});
                checkOutput("underflow", {63'd0, out_underflow}, {63'd0, e[0]});
            end
        end
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = '0;
        in_prod   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_in_ready",  {63'd0, in_ready},      64'd0);
        checkOutput("rst_out_valid", {63'd0, out_valid},     64'd0);
        checkOutput("rst_result",    {32'd0, out_result},    64'd0);
        checkOutput("rst_ovf",       {63'd0, out_overflow},  64'd0);
        checkOutput("rst_unf",       {63'd0, out_underflow}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;

        applyStimulus(1'b0, 10'd127, 48'h900000000000, 32'h40100000, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("lat_early", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        checkOutput("lat_out",   {63'd0, out_valid}, 64'd1);
        @(posedge clk);
        #1;

        applyStimulus(1'b0, 10'd127,  48'h400000000000, 32'h3F800000, 1'b0, 1'b0);
        applyStimulus(1'b0, 10'd127,  48'h400000400000, 32'h3F800000, 1'b0, 1'b0);
        applyStimulus(1'b1, 10'd127,  48'h400000C00000, 32'hBF800002, 1'b0, 1'b0);
        applyStimulus(1'b0, 10'd127,  48'h400000400001, 32'h3F800001, 1'b0, 1'b0);
        applyStimulus(1'b0, 10'd126,  48'h800001800000, 32'h3F800002, 1'b0, 1'b0);
        applyStimulus(1'b0, 10'd127,  48'h7FFFFFC00000, 32'h40000000, 1'b0, 1'b0);
        applyStimulus(1'b0, 10'd254,  48'h900000000000, 32'h7F800000, 1'b1, 1'b0);
        applyStimulus(1'b0, 10'd254,  48'h7FFFFFC00000, 32'h7F800000, 1'b1, 1'b0);
        applyStimulus(1'b1, 10'd0,    48'h400000000000, 32'h80000000, 1'b0, 1'b1);
        applyStimulus(1'b0, 10'd1,    48'h400000000000, 32'h00800000, 1'b0, 1'b0);
        applyStimulus(1'b1, 10'h3FB,  48'h400000000000, 32'h80000000, 1'b0, 1'b1);
        applyStimulus(1'b0, 10'h1FF,  48'h900000000000, 32'h7F800000, 1'b1, 1'b0);
        applyStimulus(1'b0, 10'h200,  48'h900000000000, 32'h00000000, 1'b0, 1'b1);
        applyStimulus(1'b1, 10'd127,  48'h000000000000, 32'h80000000, 1'b0, 1'b0);
        waitDrain();

        // Backpressure: consumer stalls for 6 cycles while 4 beats are offered.
        out_ready = 1'b0;
        bpBase    = acceptCount;
        fork
            begin
                applyStimulus(1'b0, 10'd127, 48'h900000000000, 32'h40100000, 1'b0, 1'b0);
                applyStimulus(1'b0, 10'd127, 48'h400000000000, 32'h3F800000, 1'b0, 1'b0);
                applyStimulus(1'b0, 10'd127, 48'h7FFFFFC00000, 32'h40000000, 1'b0, 1'b0);
                applyStimulus(1'b0, 10'd127, 48'h400000400001, 32'h3F800001, 1'b0, 1'b0);
            end
            begin
                repeat (2) @(posedge clk);
                @(negedge clk);
                checkOutput("bp_accepted", 64'(acceptCount - bpBase), 64'd2);
                checkOutput("bp_in_ready", {63'd0, in_ready}, 64'd0);
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        waitDrain();
        checkOutput("bp_total", 64'(acceptCount - bpBase), 64'd4);

        // Reset with two beats in flight, consumer stalled so nothing leaves.
        out_ready = 1'b0;
        applyStimulus(1'b0, 10'd127, 48'h900000000000, 32'h40100000, 1'b0, 1'b0);
        applyStimulus(1'b0, 10'd127, 48'h400000000000, 32'h3F800000, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_in_ready_comb", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("midrst_in_ready",  {63'd0, in_ready},  64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        expQ.delete();
        out_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checkOutput("midrst_flushed", {63'd0, out_valid}, 64'd0);
        end
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 10'd127, 48'h900000000000, 32'hC0100000, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("postrst_lat_early", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        checkOutput("postrst_lat_out",   {63'd0, out_valid}, 64'd1);
        waitDrain();

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
